// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage RV32I pipeline.
//
// Sits directly downstream of the ID/EX register. Computes the ALU, branch and
// jump results for the instruction currently in EX, drives the EX forwarding
// bus and the branch/jump redirect back upstream, and holds the EX/MEM pipeline
// register that feeds the MEM stage.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                global enable; 0 holds every register
//   stall_in              MEM busy; holds the EX/MEM register
//   pc, r1_data, r2_data  instruction pc and (already forwarded) operands
//   rd_addr, imm          destination register, sign-extended immediate
//   ins_type/details/diff opcode, funct3, funct7[5]
//   forward_ex_*          combinational EX forwarding bus
//   load_hazard           a LOAD with rd!=0 is in EX (combinational)
//   jump_enable/addr      redirect request and target (combinational)
//   output_*              EX/MEM register outputs
// -----------------------------------------------------------------------------
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            stall_in,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] r1_data,
    input  logic [XLEN-1:0] r2_data,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] imm,
    input  logic [6:0]      ins_type,
    input  logic [2:0]      ins_details,
    input  logic            ins_diff,
    output logic            forward_ex_enable,
    output logic [4:0]      forward_ex_addr,
    output logic [XLEN-1:0] forward_ex_data,
    output logic            load_hazard,
    output logic            jump_enable,
    output logic [XLEN-1:0] jump_addr,
    output logic [4:0]      output_rd_addr,
    output logic [XLEN-1:0] output_result,
    output logic [XLEN-1:0] output_store_data,
    output logic [6:0]      output_ins_type,
    output logic [2:0]      output_ins_details,
    output logic            output_wb_enable
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] addr_sum;      // r1_data + imm: memory address and JALR base
    logic [XLEN-1:0] pc_imm;        // pc + imm: AUIPC, JAL and branch target
    logic            branch_taken;
    logic            is_load;
    logic            wb_capable;
    logic            jump_req;
    logic            wb_enable_next;
    logic [XLEN-1:0] result_next;

    // ---------------------------------------------------------------- ALU ---
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave it unassigned and infer a latch.
        op_b       = (ins_type == OPC_OP) ? r2_data : imm;
        shamt      = op_b[4:0];
        alu_result = '0;
        case (ins_details)
            3'b000: alu_result = (ins_type == OPC_OP && ins_diff) ? r1_data - op_b
                                                                  : r1_data + op_b;
            3'b001: alu_result = r1_data << shamt;
            3'b010: alu_result = {{(XLEN-1){1'b0}}, $signed(r1_data) < $signed(op_b)};
            3'b011: alu_result = {{(XLEN-1){1'b0}}, r1_data < op_b};
            3'b100: alu_result = r1_data ^ op_b;
            3'b101: alu_result = ins_diff ? XLEN'($signed(r1_data) >>> shamt)
                                          : r1_data >> shamt;
            3'b110: alu_result = r1_data | op_b;
            3'b111: alu_result = r1_data & op_b;
            default: alu_result = '0;
        endcase
    end

    // ------------------------------------------------------ branch compare ---
    always_comb begin
        branch_taken = 1'b0;
        case (ins_details)
            3'b000: branch_taken = (r1_data == r2_data);
            3'b001: branch_taken = (r1_data != r2_data);
            3'b100: branch_taken = ($signed(r1_data) <  $signed(r2_data));
            3'b101: branch_taken = ($signed(r1_data) >= $signed(r2_data));
            3'b110: branch_taken = (r1_data <  r2_data);
            3'b111: branch_taken = (r1_data >= r2_data);
            default: branch_taken = 1'b0;  // 010/011 are never taken
        endcase
    end

    // ------------------------------------------------- result and redirect ---
    assign addr_sum = r1_data + imm;
    assign pc_imm   = pc + imm;

    always_comb begin
        result_next = '0;
        wb_capable  = 1'b0;
        jump_req    = 1'b0;
        jump_addr   = '0;
        is_load     = 1'b0;
        case (ins_type)
            OPC_OP, OPC_OP_IMM: begin
                result_next = alu_result;
                wb_capable  = 1'b1;
            end
            OPC_LOAD: begin
                result_next = addr_sum;
                wb_capable  = 1'b1;
                is_load     = 1'b1;
            end
            OPC_STORE: result_next = addr_sum;
            OPC_BRANCH: begin
                jump_req  = branch_taken;
                jump_addr = pc_imm;
            end
            OPC_JAL: begin
                result_next = pc + XLEN'(4);
                wb_capable  = 1'b1;
                jump_req    = 1'b1;
                jump_addr   = pc_imm;
            end
            OPC_JALR: begin
                result_next = pc + XLEN'(4);
                wb_capable  = 1'b1;
                jump_req    = 1'b1;
                jump_addr   = {addr_sum[XLEN-1:1], 1'b0};
            end
            OPC_LUI: begin
                result_next = imm;
                wb_capable  = 1'b1;
            end
            OPC_AUIPC: begin
                result_next = pc_imm;
                wb_capable  = 1'b1;
            end
            default: ;  // unknown opcode behaves as a NOP
        endcase
    end

    assign wb_enable_next    = wb_capable && (rd_addr != 5'd0);
    assign forward_ex_enable = wb_enable_next && !is_load;
    assign forward_ex_addr   = rd_addr;
    assign forward_ex_data   = result_next;
    assign load_hazard       = is_load && (rd_addr != 5'd0);

    // A stalled branch must not redirect yet: upstream holds under the same
    // stall, so the request reappears once stall_in drops.
    assign jump_enable = jump_req && rdy_in && !stall_in && !rst_in;

    // ---------------------------------------------------- EX/MEM register ---
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst_in) begin
            output_rd_addr     <= 5'd0;
            output_result      <= '0;
            output_store_data  <= '0;
            output_ins_type    <= OPC_OP_IMM;  // ADDI x0 = NOP
            output_ins_details <= 3'd0;
            output_wb_enable   <= 1'b0;
        end else if (rdy_in && !stall_in) begin
            output_rd_addr     <= rd_addr;
            output_result      <= result_next;
            output_store_data  <= r2_data;
            output_ins_type    <= ins_type;
            output_ins_details <= ins_details;
            output_wb_enable   <= wb_enable_next;
        end
    end

endmodule
